// File: rtl/demux_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin demux scheduler.
package demux_sched_pkg;
  localparam int NOUT = 4;
  localparam int SELW = 2;

  typedef enum logic [1:0] {IDLE, ARB, XFER, DRAIN} state_t;
endpackage

// File: rtl/demux_rr_scheduler_if.sv
// Source/sink handshake bundle between producer, scheduler and demux branches.
interface demux_rr_scheduler_if #(parameter int DW = 8);
  import demux_sched_pkg::*;

  logic [NOUT-1:0] cfg_mask;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_last;
  logic            in_ready;
  logic [NOUT-1:0] out_valid;
  logic [DW-1:0]   out_data;
  logic [NOUT-1:0] out_ready;
  logic [SELW-1:0] sel;
  logic            en;

  modport master (
    output cfg_mask, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, sel, en
  );

  modport slave (
    input  cfg_mask, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, sel, en
  );
endinterface

// File: rtl/demux_rr_scheduler_rr_pick.sv
// Rotating-priority picker: first set mask bit after last_ptr, wrapping.
module rr_pick
  import demux_sched_pkg::*;
(
  input  logic [NOUT-1:0] mask,
  input  logic [SELW-1:0] last_ptr,
  output logic [SELW-1:0] pick,
  output logic            found
);
  logic [SELW-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    // k = NOUT wraps back to last_ptr itself, so a lone enabled branch is re-granted
    for (int unsigned k = 1; k <= NOUT; k++) begin
      idx = last_ptr + SELW'(k);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin burst scheduler for a 1-to-4 demux with a one-entry output buffer.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  demux_rr_scheduler_if.slave bus
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  state_t          state, state_nx;
  logic [SELW-1:0] sel_q, last_ptr, pick;
  logic            found;
  logic [CW-1:0]   count;
  logic            buf_vld;
  logic [DW-1:0]   buf_data;
  logic            in_ready, accept, consume, burst_end;
  logic [NOUT-1:0] out_valid;

  rr_pick u_pick (
    .mask     (bus.cfg_mask),
    .last_ptr (last_ptr),
    .pick     (pick),
    .found    (found)
  );

  assign consume   = buf_vld & bus.out_ready[sel_q];
  assign in_ready  = (state == XFER) & (~buf_vld | bus.out_ready[sel_q]);
  assign accept    = bus.in_valid & in_ready;
  assign burst_end = (count == CW'(BURST - 1)) | bus.in_last;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid && (bus.cfg_mask != '0)) state_nx = ARB;
      ARB:     state_nx = found ? XFER : IDLE;
      XFER:    if (accept && burst_end) state_nx = DRAIN;
      DRAIN:   if (!buf_vld || consume) state_nx = bus.in_valid ? ARB : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      last_ptr <= '1;
      count    <= '0;
      buf_vld  <= 1'b0;
      buf_data <= '0;
    end else begin
      state <= state_nx;
      // sel only moves in ARB, which is never entered with a beat still buffered
      if (state == ARB && found) begin
        sel_q    <= pick;
        last_ptr <= pick;
        count    <= '0;
      end else if (accept) begin
        count <= count + 1'b1;
      end
      if (accept) begin
        buf_data <= bus.in_data;
        buf_vld  <= 1'b1;
      end else if (consume) begin
        buf_vld <= 1'b0;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    if (buf_vld) out_valid[sel_q] = 1'b1;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = buf_data;
  assign bus.sel       = sel_q;
  assign bus.en        = (state == XFER) || (state == DRAIN);
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Bench for demux_rr_scheduler: transaction-level grant model plus directed scenarios.
module tb_demux_rr_scheduler;
  import demux_sched_pkg::*;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_rr_scheduler_if #(.DW(DW)) bus ();

  demux_rr_scheduler #(.DW(DW), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            br;
    logic [DW-1:0] d;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    checks = 0;
  int    errors = 0;
  int    m_last = 3;
  int    m_cnt  = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    onehot = '0;
    onehot[i[1:0]] = 1'b1;
  endfunction

  function automatic int next_grant(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++)
      if (m[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction

  // Model: each beat's branch follows from round-robin order over BURST/in_last grants.
  task automatic monitor();
    logic [3:0]    prev_ov  = '0;
    logic [3:0]    prev_rdy = '0;
    logic [DW-1:0] prev_d   = '0;
    logic [1:0]    prev_sel = '0;
    bit            pend     = 0;
    int            pend_br  = 0;
    logic [DW-1:0] pend_d   = '0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_last  = 3;
        m_cnt   = 0;
        pend    = 0;
        prev_ov = '0;
      end else begin
        if (pend)
          check_eq("latency", {bus.out_valid, bus.out_data}, {onehot(pend_br), pend_d});
        if (prev_ov != '0 && (prev_ov & prev_rdy) == '0)
          check_eq("hold", {bus.out_valid, bus.out_data, bus.sel}, {prev_ov, prev_d, prev_sel});
        if (bus.out_valid != '0)
          check_eq("valid_sel_en", {bus.out_valid, bus.en}, {onehot(int'(bus.sel)), 1'b1});
        if ((bus.out_valid & bus.out_ready) != '0) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_beat", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_eq("deliver", {bus.sel, bus.out_data}, {2'(e.br), e.d});
          end
          log_q.push_back('{br: int'(bus.sel), d: bus.out_data});
        end
        if (bus.in_valid && bus.in_ready) begin
          if (m_cnt == 0) m_last = next_grant(bus.cfg_mask, m_last);
          exp_q.push_back('{br: m_last, d: bus.in_data});
          pend    = 1;
          pend_br = m_last;
          pend_d  = bus.in_data;
          m_cnt++;
          if (m_cnt == BURST || bus.in_last) m_cnt = 0;
        end else begin
          pend = 0;
        end
        prev_ov  = bus.out_valid;
        prev_rdy = bus.out_ready;
        prev_d   = bus.out_data;
        prev_sel = bus.sel;
      end
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) check_eq("accept_timeout", {31'd0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_log(input string name, input int base, input int br[], input int d[]);
    check_eq({name, "_count"}, log_q.size() - base, br.size());
    for (int k = 0; k < br.size(); k++)
      if (base + k < log_q.size())
        check_eq(name, {log_q[base + k].br, 24'd0, log_q[base + k].d}, {br[k], 24'd0, d[k][7:0]});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int br[];
    int dv[];
    bus.cfg_mask  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = '1;
    fork monitor(); join_none

    repeat (2) @(negedge clk);
    check_eq("reset_state", {bus.out_valid, bus.en, bus.sel, bus.in_ready, bus.out_data}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty mask: beat held off until a branch is enabled.
    base = log_q.size();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_eq("empty_mask", {bus.in_ready, bus.en, bus.out_valid}, 0);
    end
    @(posedge clk);
    #1 bus.cfg_mask = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check_eq("arb_cycle", {bus.en, bus.in_ready}, 0);
    @(negedge clk);
    check_eq("grant_after_mask", {bus.sel, bus.en, bus.in_ready}, {2'd2, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (4) @(negedge clk);
    br = '{2}; dv = '{8'h77};
    check_log("empty_mask_log", base, br, dv);

    // Round-robin rotation over 16 continuous beats.
    do_reset();
    bus.cfg_mask = 4'b1111;
    base = log_q.size();
    for (int k = 0; k < 16; k++) send_beat(8'(k), 1'b0);
    repeat (8) @(negedge clk);
    br = new[16]; dv = new[16];
    for (int k = 0; k < 16; k++) begin br[k] = k / 4; dv[k] = k; end
    check_log("rr_rotation", base, br, dv);

    // Mask skipping with 2-beat packets.
    bus.cfg_mask = 4'b1010;
    base = log_q.size();
    for (int p = 0; p < 3; p++) begin
      send_beat(8'(8'h20 + 2 * p), 1'b0);
      send_beat(8'(8'h21 + 2 * p), 1'b1);
    end
    repeat (8) @(negedge clk);
    br = '{1, 1, 3, 3, 1, 1}; dv = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    check_log("mask_skip", base, br, dv);

    // Backpressure on granted branch 2; other branches ready but ignored.
    bus.cfg_mask  = 4'b0100;
    bus.out_ready = 4'b1011;
    base = log_q.size();
    send_beat(8'h40, 1'b0);
    fork
      begin
        send_beat(8'h41, 1'b0);
        send_beat(8'h42, 1'b1);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check_eq("backpressure", {bus.in_ready, bus.sel, bus.out_valid, bus.out_data},
                   {1'b0, 2'd2, 4'b0100, 8'h40});
        end
        @(posedge clk);
        #1 bus.out_ready = '1;
      end
    join
    repeat (8) @(negedge clk);
    br = '{2, 2, 2}; dv = '{8'h40, 8'h41, 8'h42};
    check_log("backpressure_log", base, br, dv);

    // Mask change mid-burst only affects the next arbitration.
    do_reset();
    bus.cfg_mask = 4'b1111;
    base = log_q.size();
    send_beat(8'h50, 1'b0);
    send_beat(8'h51, 1'b0);
    bus.cfg_mask = 4'b0010;
    send_beat(8'h52, 1'b0);
    send_beat(8'h53, 1'b0);
    send_beat(8'h54, 1'b0);
    send_beat(8'h55, 1'b1);
    repeat (8) @(negedge clk);
    br = '{0, 0, 0, 0, 1, 1}; dv = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    check_log("mask_change", base, br, dv);

    // Reset while a beat sits in the buffer.
    bus.cfg_mask  = 4'b1111;
    bus.out_ready = 4'b0000;
    base = log_q.size();
    send_beat(8'h60, 1'b0);
    check_eq("buffered_before_reset", {bus.out_valid, bus.out_data}, {4'b0100, 8'h60});
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", {bus.out_valid, bus.en, bus.sel}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = '1;
    send_beat(8'h61, 1'b1);
    repeat (6) @(negedge clk);
    br = '{0}; dv = '{8'h61};
    check_log("post_reset_grant", base, br, dv);

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
